// File: rtl/key_pkg.sv
// Scan-code constants, the key event layout and the set-2 to ASCII translation
// shared by the keyboard event decoder.
package key_pkg;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_event_t;

    // Returns {hit, char}; hit is 0 for codes that produce no character.
    function automatic logic [8:0] scan_to_ascii(input logic [7:0] code,
                                                 input logic       shift,
                                                 input logic       caps);
        logic [7:0] ch;
        logic [7:0] sym;
        logic       hit;
        ch  = 8'h00;
        sym = 8'h00;
        hit = 1'b1;
        case (code)
            8'h1C: ch = "a";   8'h32: ch = "b";   8'h21: ch = "c";
            8'h23: ch = "d";   8'h24: ch = "e";   8'h2B: ch = "f";
            8'h34: ch = "g";   8'h33: ch = "h";   8'h43: ch = "i";
            8'h3B: ch = "j";   8'h42: ch = "k";   8'h4B: ch = "l";
            8'h3A: ch = "m";   8'h31: ch = "n";   8'h44: ch = "o";
            8'h4D: ch = "p";   8'h15: ch = "q";   8'h2D: ch = "r";
            8'h1B: ch = "s";   8'h2C: ch = "t";   8'h3C: ch = "u";
            8'h2A: ch = "v";   8'h1D: ch = "w";   8'h22: ch = "x";
            8'h35: ch = "y";   8'h1A: ch = "z";
            8'h45: begin ch = "0"; sym = ")"; end
            8'h16: begin ch = "1"; sym = "!"; end
            8'h1E: begin ch = "2"; sym = "@"; end
            8'h26: begin ch = "3"; sym = "#"; end
            8'h25: begin ch = "4"; sym = "$"; end
            8'h2E: begin ch = "5"; sym = "%"; end
            8'h36: begin ch = "6"; sym = "^"; end
            8'h3D: begin ch = "7"; sym = "&"; end
            8'h3E: begin ch = "8"; sym = "*"; end
            8'h46: begin ch = "9"; sym = "("; end
            SC_SPACE: ch = 8'h20;
            SC_ENTER: ch = 8'h0D;
            SC_BKSP:  ch = 8'h08;
            default:  hit = 1'b0;
        endcase
        // Caps Lock only affects letters; Shift selects the digit-row symbols.
        if (ch >= "a" && ch <= "z") begin
            if (shift ^ caps) ch = ch - 8'h20;
        end else if (sym != 8'h00 && shift) begin
            ch = sym;
        end
        return {hit, ch};
    endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Event input and character output handshake of the keyboard event decoder.
interface key_event_decoder_if;
    logic       key_valid;
    logic [9:0] key_value;
    logic       ascii_valid;
    logic [7:0] ascii_data;
    logic       ascii_ready;

    modport master (output key_valid, output key_value, output ascii_ready,
                    input  ascii_valid, input  ascii_data);
    modport slave  (input  key_valid, input  key_value, input  ascii_ready,
                    output ascii_valid, output ascii_data);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO lands only when a pop
// frees the head in the same cycle.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_q, wr_d;
    logic [AW:0]       rd_q, rd_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;
    logic              rd_en;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (wr_en) wr_d = wr_q + 1'b1;
        if (rd_en) rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Turns PS/2 make/break events into ASCII characters, tracking Shift, Caps Lock
// and arrow-key state, and queues characters for a valid/ready consumer.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    key_event_decoder_if.slave    bus,
    output logic                  shift_held,
    output logic                  caps_lock,
    output logic [3:0]            arrow_held,
    output logic                  overflow
);
    key_event_t ev;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_lock_q, caps_lock_d;
    logic       caps_down_q, caps_down_d;
    logic [3:0] arrow_q, arrow_d;
    logic       overflow_q, overflow_d;
    logic [8:0] xlat;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] head;

    assign ev = key_event_t'(bus.key_value);

    // Translation sees the modifier state as it was before this event.
    assign xlat = scan_to_ascii(ev.code, lshift_q | rshift_q, caps_lock_q);
    assign push = bus.key_valid && !ev.ext && !ev.brk && xlat[8];
    assign pop  = bus.ascii_ready && !empty;

    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_lock_d = caps_lock_q;
        caps_down_d = caps_down_q;
        arrow_d     = arrow_q;
        overflow_d  = overflow_q | (push && full && !pop);
        if (bus.key_valid) begin
            if (!ev.ext) begin
                if (ev.code == SC_LSHIFT) lshift_d = !ev.brk;
                if (ev.code == SC_RSHIFT) rshift_d = !ev.brk;
                if (ev.code == SC_CAPS) begin
                    if (ev.brk) begin
                        caps_down_d = 1'b0;
                    end else if (!caps_down_q) begin
                        caps_lock_d = !caps_lock_q;
                        caps_down_d = 1'b1;
                    end
                end
            end else begin
                if (ev.code == SC_UP)    arrow_d[3] = !ev.brk;
                if (ev.code == SC_DOWN)  arrow_d[2] = !ev.brk;
                if (ev.code == SC_LEFT)  arrow_d[1] = !ev.brk;
                if (ev.code == SC_RIGHT) arrow_d[0] = !ev.brk;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_lock_q <= 1'b0;
            caps_down_q <= 1'b0;
            arrow_q     <= 4'b0000;
            overflow_q  <= 1'b0;
        end else begin
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_lock_q <= caps_lock_d;
            caps_down_q <= caps_down_d;
            arrow_q     <= arrow_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (xlat[7:0]),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.ascii_valid = !empty;
    assign bus.ascii_data  = head;
    assign shift_held      = lshift_q | rshift_q;
    assign caps_lock       = caps_lock_q;
    assign arrow_held      = arrow_q;
    assign overflow        = overflow_q;

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Consumes decoded PS/2 scan-code events from the keyboard front end and turns them into ASCII characters for the game logic. Tracks modifier state (Shift, Caps Lock) and the held state of the four extended arrow keys, and buffers translated characters in a small first-word-fall-through FIFO with a valid/ready output handshake. Sits directly downstream of the PS/2 keyboard receiver and upstream of the text/command consumer.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, 2..16.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe: `key_value` holds a new event.
- `key_value`  in  10  `{brk, ext, code[7:0]}`. `brk` = release, `ext` = E0-prefixed.
- `ascii_valid`  out  1  FIFO non-empty.
- `ascii_data`  out  8  FIFO head character, meaningful only when `ascii_valid` is high.
- `ascii_ready`  in  1  consumer accepts the head when `ascii_valid && ascii_ready`.
- `shift_held`  out  1  either Shift key (0x12, 0x59, non-ext) currently pressed.
- `caps_lock`  out  1  Caps Lock toggle state.
- `arrow_held`  out  4  `{up E0 75, down E0 72, left E0 6B, right E0 74}` currently pressed.
- `overflow`  out  1  sticky: a character was dropped because the FIFO was full.

## Operation
- Events are processed only when `key_valid` is 1. All state updates happen on that edge.
- Shift: track left and right Shift separately. `shift_held` = L | R. A make event sets the bit; a break event clears it.
- Caps Lock (0x58, non-ext):
  - Toggles on a make event only when internal `caps_down` is 0, then sets `caps_down`.
  - A break event clears `caps_down`. Typematic repeat makes therefore do not re-toggle.
- Arrows: a make event sets the `arrow_held` bit; a break event clears it. Non-arrow ext codes are ignored.
- Translation applies to non-ext make events only. Break events never push.
  - Letters (US set-2 map, 0x1C=a … 0x1A=z): uppercase when `shift_held ^ caps_lock`.
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 → '0'..'9'. With Shift, they map to ) ! @ # $ % ^ & * ( instead. Caps Lock has no effect on digits.
  - 0x29 → 0x20, 0x5A → 0x0D, 0x66 → 0x08.
  - Any other code: no push.
- Modifier state used for translation is the state before the current event.
- Push: a translated character is written at the tail.
  - If full and no pop occurs in the same cycle, the character is dropped and `overflow` is set. `overflow` is cleared only by `rst`.
- Pop: occurs when `ascii_valid && ascii_ready`.
  - Simultaneous push and pop while full: both occur, nothing is dropped.
  - Simultaneous push and pop while empty: the push lands, `ascii_valid` rises next cycle.
- Pointers are `$clog2(DEPTH)+1` bits wide with a wrap bit. Full = address bits equal and wrap bits differ. Empty = pointers equal.

## Timing
- Reset values: `ascii_valid` 0, `ascii_data` 0x00, `shift_held` 0, `caps_lock` 0, `arrow_held` 4'b0000, `overflow` 0. Internal `caps_down` is 0 and both pointers are 0.
- Reset mid-operation: FIFO contents are discarded immediately (asynchronous).
- Latency: `key_valid` at edge N → `ascii_valid`/`ascii_data` valid after edge N (one cycle). Modifier and arrow outputs also update after edge N.
- `ascii_data` is stable while `ascii_valid && !ascii_ready`. It advances to the next entry one cycle after a pop.
- Back-to-back `key_valid` on consecutive cycles must be handled. The upstream rate is far lower, but this is a hard requirement.
- Outputs are registered. The only combinational path is `ascii_ready` → pop.

## Structure
- Package `key_pkg`:
  - Scan-code localparams (`SC_LSHIFT`, `SC_RSHIFT`, `SC_CAPS`, `SC_UP`, `SC_DOWN`, `SC_LEFT`, `SC_RIGHT`, …).
  - A pure function `scan_to_ascii(code, shift, caps)` returning `{hit, char[7:0]}`.
  - A struct `key_event_t {brk, ext, code}` matching the 10-bit `key_value` layout.
- Sub-module `sync_fifo`: parameterised width/depth FWFT FIFO with push, pop, full, empty. The top level handles translation, modifiers, arrows and overflow.

## Test plan
- Reset, then make 0x1C with ready=1 → `ascii_valid` pulses one cycle with `ascii_data`=0x61 ('a'). `overflow`=0.
- Make 0x12, make 0x16, break 0x12, make 0x16 → characters 0x21 ('!') then 0x31 ('1'). `shift_held` goes 1 then 0.
- Make 0x58 three times (repeat), break 0x58, make 0x1C, then make 0x12 + make 0x1C → `caps_lock`=1 after the first make only. Characters are 0x41 ('A') then 0x61 ('a').
- Ext make 0x75, ext make 0x6B, ext break 0x75 → `arrow_held` goes 1000, 1010, 0010. No FIFO push.
- ready=0, push DEPTH+1 letters 'a'..'e' → the first DEPTH are held, 'e' is dropped, `overflow`=1. Raising ready drains 'a','b','c','d' in order.
- FIFO full, push and pop in the same cycle → the pop is taken and the push is stored. `overflow` stays 0 and the count stays DEPTH.
